// File: rtl/iir_level_meter_if.sv
// Level-meter bus: filtered sample stream in, windowed level results out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the sample side is valid-only, results are a one-cycle pulse plus held values.
// Ports: y/y_valid driven by the filter side (master); level_valid, peak, abs_sum, pass,
//        settled, win_count driven by the meter (slave).
interface iir_level_meter_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40
);
    logic signed [DATA_W-1:0] y;
    logic                     y_valid;
    logic                     level_valid;
    logic        [DATA_W-1:0] peak;
    logic        [ACC_W-1:0]  abs_sum;
    logic                     pass;
    logic                     settled;
    logic        [15:0]       win_count;

    modport master (
        output y, y_valid,
        input  level_valid, peak, abs_sum, pass, settled, win_count
    );

    modport slave (
        input  y, y_valid,
        output level_valid, peak, abs_sum, pass, settled, win_count
    );
endinterface

// File: rtl/iir_level_meter.sv
// Windowed level meter on the IIR output: peak |y|, sum |y| and a pass/stop flag per WINDOW samples.
// Latency: results and level_valid appear 1 cycle after the edge accepting a window's last sample.
// Backpressure: none; every y_valid sample is consumed, gaps of any length are tolerated.
// Ports: clk, reset (sync, active-low); bus.slave carries y/y_valid in and the results out.
module iir_level_meter #(
    parameter int DATA_W = 32,
    parameter int WINDOW = 24,
    parameter int ACC_W  = 40,
    parameter int SETTLE = 48,
    parameter int THRESH = 524288
) (
    input  logic               clk,
    input  logic               reset,
    iir_level_meter_if.slave   bus
);
    typedef enum logic {
        S_SETTLE  = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [15:0]         settle_cnt;
    logic [8:0]          sample_cnt;
    logic [DATA_W-1:0]   peak_acc;
    logic [ACC_W-1:0]    sum_acc;

    logic [DATA_W-1:0]   mag;
    logic [DATA_W-1:0]   new_peak;
    logic [ACC_W-1:0]    new_sum;
    logic                accept;
    logic                win_done;

    // |y|; the most negative code has no positive twin, so clamp it to full scale.
    always_comb begin
        mag = bus.y;
        if (bus.y == {1'b1, {(DATA_W-1){1'b0}}})
            mag = {1'b0, {(DATA_W-1){1'b1}}};
        else if (bus.y[DATA_W-1])
            mag = -bus.y;
    end

    // Window totals including the current sample, so the last sample lands in the result.
    assign new_peak = (mag > peak_acc) ? mag : peak_acc;
    assign new_sum  = sum_acc + {{(ACC_W-DATA_W){1'b0}}, mag};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        win_done   = 1'b0;
        case (state)
            S_SETTLE: begin
                if (bus.y_valid && settle_cnt == 16'(SETTLE - 1))
                    state_next = S_MEASURE;
            end
            S_MEASURE: begin
                accept   = bus.y_valid;
                win_done = bus.y_valid && (sample_cnt == 9'(WINDOW - 1));
            end
            default: state_next = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (SETTLE == 0)
                state <= S_MEASURE;
            else
                state <= S_SETTLE;
            settle_cnt      <= '0;
            sample_cnt      <= '0;
            peak_acc        <= '0;
            sum_acc         <= '0;
            bus.level_valid <= 1'b0;
            bus.peak        <= '0;
            bus.abs_sum     <= '0;
            bus.pass        <= 1'b0;
            bus.settled     <= 1'b0;
            bus.win_count   <= '0;
        end else begin
            state           <= state_next;
            bus.level_valid <= win_done;
            // Sticky: once measuring, settled stays up until the next reset.
            if (state_next == S_MEASURE)
                bus.settled <= 1'b1;
            if (state == S_SETTLE && bus.y_valid)
                settle_cnt <= settle_cnt + 16'd1;
            if (win_done) begin
                bus.peak      <= new_peak;
                bus.abs_sum   <= new_sum;
                bus.pass      <= (new_peak >= DATA_W'(THRESH));
                bus.win_count <= bus.win_count + 16'd1;
                peak_acc      <= '0;
                sum_acc       <= '0;
                sample_cnt    <= '0;
            end else if (accept) begin
                peak_acc   <= new_peak;
                sum_acc    <= new_sum;
                sample_cnt <= sample_cnt + 9'd1;
            end
        end
    end
endmodule

// File: doc/iir_level_meter.md
Name: iir_level_meter

Overview:
- Downstream consumer of pipelined_iir. Measures the filtered output y over fixed windows of samples and reports peak magnitude, sum of magnitudes and a pass/stop decision.
- Lets the bandstop response be checked automatically in hardware and in simulation: in-band tones must read "stopped", out-of-band tones (e.g. 2 kHz at 48 kHz sampling) must read "passed".
- Samples are signed Q20 (1048576 = 1.0).

Parameters:
DATA_W, 32, sample width (signed, Q20)
WINDOW, 24, valid samples per measurement window (2..256)
ACC_W, 40, magnitude-sum accumulator width (≥ DATA_W + 8)
SETTLE, 48, valid samples discarded after reset, to skip the IIR start-up transient (0..65535)
THRESH, 524288, peak threshold for pass decision (Q20, 0.5)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge)
y  input  DATA_W  signed filter output sample
y_valid  input  1  y is a new sample this cycle (tie high when the IIR runs every clock)
level_valid  output  1  one-cycle pulse: window results updated
peak  output  DATA_W  max |y| in last completed window (unsigned)
abs_sum  output  ACC_W  sum of |y| over last completed window (unsigned)
pass  output  1  1 when peak >= THRESH for last completed window
settled  output  1  settle phase finished
win_count  output  16  number of completed windows, wraps at 65535->0

Behaviour:
- Reset values (reset==0 at a clk edge):
  - All outputs 0.
  - Internal sample counter, peak and sum accumulators 0.
  - FSM enters SETTLE; or MEASURE if SETTLE==0, with settled=1 on the first cycle after reset release.
- Reset overrides y_valid. Reset mid-window discards the partial window: no level_valid, outputs cleared.
- Magnitude:
  - |y| = -y for negative y.
  - y = -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- FSM states:
  - SETTLE: count y_valid samples, values ignored. On the SETTLE-th valid sample go to MEASURE and set settled=1 next cycle. That sample is not measured.
  - MEASURE: each valid sample updates peak_acc = max(peak_acc, |y|) and sum_acc += |y|, and increments sample_cnt.
  - On the WINDOW-th valid sample, the final values include that sample. Next cycle:
    - level_valid=1
    - peak, abs_sum, pass take the window values
    - win_count increments
    - accumulators and sample_cnt restart at 0
  - Latency: level_valid asserts exactly 1 cycle after the edge that accepts the last sample of the window.
  - Back-to-back windows with y_valid continuously high: no samples lost. The first sample of the next window is accepted on the same edge that registers the results.
- y_valid low: no state change. Gaps of any length are allowed.
- Output holding: peak, abs_sum and pass hold between pulses; level_valid is low except on the one-cycle pulse.
- Widths: sum_acc cannot overflow for WINDOW ≤ 256 with ACC_W ≥ DATA_W+8. pass uses an unsigned compare of peak against THRESH.
- settled stays 1 until the next reset.

Test Plan:
- SETTLE=0, WINDOW=24, one period of the 2 kHz sine (0, 271391, 524288, 741455, 908093, 1012846, 1048576, … , -271391) with y_valid=1 -> one level_valid pulse 1 cycle after the 24th sample; peak=1048576, abs_sum=15929444, pass=1, win_count=1.
- SETTLE=0, y held at 0 for 48 samples -> two level_valid pulses 24 cycles apart; peak=0, abs_sum=0, pass=0, win_count=2.
- SETTLE=10, ramp y=1..34 continuous -> settled rises after sample 10; window covers samples 11..34; peak=34, abs_sum=540, pass=0.
- Single sample y=-2^31 in an otherwise zero window -> peak=2147483647, abs_sum=2147483647, pass=1.
- y_valid toggling 1/0 each cycle over 24 valid samples of 1048576 -> level_valid 1 cycle after the 24th accepted sample (cycle 48); abs_sum=25165824.
- reset=0 asserted after 12 samples of a window, released, then 24 samples of 100 -> no pulse for the partial window; next pulse shows peak=100, abs_sum=2400, win_count=1.
